// File: rtl/ahbsub_pkg.sv
// ahbsub_pkg: shared FSM states, HTRANS encodings and the size-alignment check for ahb_sram_sub
package ahbsub_pkg;
  typedef enum logic [2:0] {IDLE, WAIT, DONE, ERR1, ERR2} ahbsub_state_t;
  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;
  function automatic logic size_aligned(input logic [6:0] addr_lo, input logic [2:0] size);
    return (addr_lo & ((7'd1 << size) - 7'd1)) == 7'd0;
  endfunction
endpackage

// File: rtl/ahbsub_mem.sv
// ahbsub_mem: DEPTH x DATA_W single-port SRAM with byte-enable write and asynchronous read
module ahbsub_mem #(
  parameter int DEPTH  = 1024,
  parameter int DATA_W = 64
) (
  input  logic                       clk,
  input  logic                       we,
  input  logic [$clog2(DEPTH)-1:0]   idx,
  input  logic [DATA_W-1:0]          wdata,
  input  logic [DATA_W/8-1:0]        wstrb,
  output logic [DATA_W-1:0]          rdata
);
  logic [DATA_W-1:0] mem [DEPTH];
  // byte lanes with a set strobe take the new data, the rest keep their contents
  always_ff @(posedge clk)
    for (int b = 0; b < DATA_W/8; b++)
      if (we && wstrb[b]) mem[idx][8*b +: 8] <= wdata[8*b +: 8];
  assign rdata = mem[idx];
endmodule

// File: rtl/ahb_sram_sub.sv
// ahb_sram_sub: AHB-Lite subordinate fronting a byte-writable SRAM with WS wait states; AHBSUB_ERR_EN enables two-cycle ERROR responses for illegal transfers
module ahb_sram_sub
  import ahbsub_pkg::*;
#(
  parameter int                ADDR_W = 32,
  parameter int                DATA_W = 64,
  parameter int                DEPTH  = 1024,
  parameter logic [ADDR_W-1:0] BASE   = 'h8000_0000,
  parameter int                WS     = 0
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                HSEL,
  input  logic [ADDR_W-1:0]   HADDR,
  input  logic                HWRITE,
  input  logic [2:0]          HSIZE,
  input  logic [1:0]          HTRANS,
  input  logic                HREADY,
  input  logic [DATA_W-1:0]   HWDATA,
  input  logic [DATA_W/8-1:0] HWSTRB,
  output logic [DATA_W-1:0]   HRDATA,
  output logic                HREADYOUT,
  output logic                HRESP
);
  localparam int LSB   = $clog2(DATA_W/8);
  localparam int IDX_W = $clog2(DEPTH);
  ahbsub_state_t state, state_n;
  logic [3:0] cnt, cnt_n;
  logic dp_valid, dp_write;
  logic [IDX_W-1:0] dp_idx;
  logic [ADDR_W-1:0] off;
  logic accept, illegal, we, unused_sig;
  logic [DATA_W-1:0] rdata;
  assign off       = HADDR - BASE;
  assign accept    = HSEL & HTRANS[1] & HREADY;
  assign HREADYOUT = !(state == WAIT || state == ERR1);
`ifdef AHBSUB_ERR_EN
  assign illegal = ((off >> (LSB + IDX_W)) != '0) || (HSIZE > 3'(LSB)) || !size_aligned(HADDR[6:0], HSIZE);
  assign HRESP   = state == ERR1 || state == ERR2;
`else
  assign illegal = 1'b0;
  assign HRESP   = 1'b0;
`endif
  assign unused_sig = &{1'b0, HTRANS[0], HSIZE, off};
  assign we         = dp_valid & dp_write & HREADYOUT & ~reset;
  assign HRDATA     = (dp_valid & ~dp_write & HREADYOUT) ? rdata : '0;
  // next state: WAIT counts down, ERR1 always moves to ERR2, every ready state handles a new accept alike
  always_comb begin
    state_n = state == WAIT ? (cnt == 4'd0 ? DONE : WAIT) :
              state == ERR1 ? ERR2 :
              !accept ? IDLE : illegal ? ERR1 : (WS > 0 ? WAIT : IDLE);
    cnt_n   = state == WAIT ? (cnt == 4'd0 ? 4'd0 : cnt - 4'd1) :
              (state != ERR1 && accept && !illegal && WS > 0) ? 4'(WS - 1) : 4'd0;
  end
  // state, counter and data-phase registers; address phase is captured only while ready
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      cnt      <= '0;
      dp_valid <= 1'b0;
      dp_write <= 1'b0;
      dp_idx   <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      if (HREADYOUT) begin
        dp_valid <= accept & ~illegal;
        dp_write <= HWRITE;
        dp_idx   <= off[LSB +: IDX_W];
      end
    end
  end
  ahbsub_mem #(.DEPTH(DEPTH), .DATA_W(DATA_W)) u_mem (
    .clk  (clk),
    .we   (we),
    .idx  (dp_idx),
    .wdata(HWDATA),
    .wstrb(HWSTRB),
    .rdata(rdata)
  );
endmodule

// File: tb/tb_ahb_sram_sub.sv
// tb_ahb_sram_sub: scoreboard bench driving three ahb_sram_sub instances (WS=0,3,5) on one shared bus
module tb_ahb_sram_sub;
  localparam logic [31:0] BASE = 32'h8000_0000;
  typedef struct {logic [63:0] data; logic resp;} exp_t;
  logic clk = 1'b0, reset = 1'b1;
  logic hsel_bus = 1'b0, hwrite = 1'b0;
  logic [31:0] haddr = '0;
  logic [2:0] hsize = 3'd3;
  logic [1:0] htrans = 2'b00, sel = 2'd0;
  logic [63:0] hwdata = '0;
  logic [7:0] hwstrb = '0;
  logic [2:0] hro, hrs;
  logic [63:0] hrd [3];
  logic hready, hresp, pend = 1'b0;
  logic [63:0] hrdata;
  logic [63:0] mdl [3][1024];
  exp_t q[$];
  int n_chk = 0, n_fail = 0;
  always #5 clk = ~clk;
  assign hready = hro[sel];
  assign hresp  = hrs[sel];
  assign hrdata = hrd[sel];
  for (genvar g = 0; g < 3; g++) begin : g_dut
    ahb_sram_sub #(.WS(g == 0 ? 0 : g == 1 ? 3 : 5)) dut (
      .clk(clk), .reset(reset), .HSEL(hsel_bus && sel == 2'(g)), .HADDR(haddr), .HWRITE(hwrite),
      .HSIZE(hsize), .HTRANS(htrans), .HREADY(hready), .HWDATA(hwdata), .HWSTRB(hwstrb),
      .HRDATA(hrd[g]), .HREADYOUT(hro[g]), .HRESP(hrs[g])
    );
  end
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  // completing data phases pop the scoreboard
  always @(negedge clk) begin
    exp_t e;
    if (reset) pend = 1'b0;
    else if (hready) begin
      if (pend) begin
        if (q.size() == 0) chk("sb_empty", 64'(q.size()), 64'd1);
        else begin
          e = q.pop_front();
          chk("rdata", hrdata, e.data);
          chk("hresp", {63'd0, hresp}, {63'd0, e.resp});
        end
      end
      pend = hsel_bus & htrans[1];
    end
  end
  task automatic xfer(input bit w, input logic [31:0] a, input logic [2:0] sz, input logic [63:0] wd,
                      input logic [7:0] st, output int waits);
    int wi;
    bit legal;
    exp_t e;
    wi = int'(((a - BASE) >> 3) & 32'd1023);
`ifdef AHBSUB_ERR_EN
    legal = (a - BASE) < 32'h2000 && sz <= 3'd3 && (a & ((32'd1 << sz) - 32'd1)) == 32'd0;
`else
    legal = 1'b1;
`endif
    hsel_bus = 1'b1; htrans = 2'b10; haddr = a; hwrite = w; hsize = sz;
    waits = 0;
    @(negedge clk);
    while (!hready && waits < 50) begin waits++; @(negedge clk); end
    if (waits >= 50) chk("accept_tmo", 64'(waits), 64'd0);
    e.data = (w || !legal) ? 64'd0 : mdl[sel][wi];
    e.resp = !legal;
    q.push_back(e);
    if (w && legal)
      for (int b = 0; b < 8; b++) if (st[b]) mdl[sel][wi][8*b +: 8] = wd[8*b +: 8];
    @(posedge clk); #1;
    hwdata = wd; hwstrb = st;
  endtask
  task automatic idle();
    int n;
    n = 0;
    hsel_bus = 1'b0; htrans = 2'b00;
    @(negedge clk);
    while (!hready && n < 50) begin n++; @(negedge clk); end
    if (n >= 50) chk("idle_tmo", 64'(n), 64'd0);
    @(posedge clk); #1;
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end
  initial begin
    int w0, w1, n;
    logic [63:0] save;
    for (int d = 0; d < 3; d++) for (int i = 0; i < 1024; i++) mdl[d][i] = '0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    for (int d = 0; d < 3; d++) begin
      chk($sformatf("rst_hready%0d", d), {63'd0, hro[d]}, 64'd1);
      chk($sformatf("rst_hresp%0d", d), {63'd0, hrs[d]}, 64'd0);
      chk($sformatf("rst_hrdata%0d", d), hrd[d], 64'd0);
    end
    @(posedge clk); #1;
    // WS=0 back-to-back write then read of the same word
    sel = 2'd0;
    xfer(1, 32'h8000_0010, 3'd3, 64'h1122334455667788, 8'hFF, w0);
    xfer(0, 32'h8000_0010, 3'd3, 64'd0, 8'h00, w1);
    idle();
    chk("t1_wr_waits", 64'(w0), 64'd0);
    chk("t1_rd_waits", 64'(w1), 64'd0);
    // partial write over a zeroed word
    xfer(1, 32'h8000_0020, 3'd3, 64'd0, 8'hFF, w0);
    xfer(1, 32'h8000_0020, 3'd3, 64'hAAAAAAAA_BBBBBBBB, 8'h0F, w0);
    xfer(0, 32'h8000_0020, 3'd3, 64'd0, 8'h00, w0);
    idle();
    chk("t3_model", mdl[0][4], 64'h00000000_BBBBBBBB);
    // out-of-range write
    xfer(1, 32'h8000_0000, 3'd3, 64'h0102030405060708, 8'hFF, w0);
    idle();
    xfer(1, 32'h8000_2000, 3'd3, 64'hDEADDEADDEADDEAD, 8'hFF, w0);
    hsel_bus = 1'b0; htrans = 2'b00;
    @(negedge clk);
`ifdef AHBSUB_ERR_EN
    chk("t4_err1_hready", {63'd0, hready}, 64'd0);
    chk("t4_err1_hresp", {63'd0, hresp}, 64'd1);
`else
    chk("t4_hready", {63'd0, hready}, 64'd1);
    chk("t4_hresp", {63'd0, hresp}, 64'd0);
`endif
    @(posedge clk); #1;
    idle();
    xfer(0, 32'h8000_0000, 3'd3, 64'd0, 8'h00, w0);
    idle();
    // misaligned word write
    xfer(1, 32'h8000_0006, 3'd2, 64'hCAFEF00D_12345678, 8'hF0, w0);
    hsel_bus = 1'b0; htrans = 2'b00;
    @(negedge clk);
`ifdef AHBSUB_ERR_EN
    chk("t5_err1_hready", {63'd0, hready}, 64'd0);
    chk("t5_err1_hresp", {63'd0, hresp}, 64'd1);
`else
    chk("t5_hresp", {63'd0, hresp}, 64'd0);
`endif
    @(posedge clk); #1;
    idle();
    xfer(0, 32'h8000_0000, 3'd3, 64'd0, 8'h00, w0);
    idle();
    // WS=3 read: exactly three wait cycles
    sel = 2'd1;
    xfer(1, 32'h8000_0000, 3'd3, 64'h5A5A_0000_FFFF_1234, 8'hFF, w0);
    idle();
    xfer(0, 32'h8000_0000, 3'd3, 64'd0, 8'h00, w0);
    hsel_bus = 1'b0; htrans = 2'b00;
    n = 0;
    @(negedge clk);
    while (!hready && n < 20) begin n++; @(negedge clk); end
    chk("t2_waits", 64'(n), 64'd3);
    @(posedge clk); #1;
    // WS=5: reset during the wait of a write discards it
    sel = 2'd2;
    xfer(1, 32'h8000_0040, 3'd3, 64'h0F0F_0F0F_0F0F_0F0F, 8'hFF, w0);
    idle();
    save = mdl[2][8];
    xfer(1, 32'h8000_0040, 3'd3, 64'hFFFF_EEEE_DDDD_CCCC, 8'hFF, w0);
    hsel_bus = 1'b0; htrans = 2'b00;
    @(negedge clk);
    chk("t6_wait_hready", {63'd0, hready}, 64'd0);
    @(negedge clk);
    @(posedge clk); #1;
    reset = 1'b1;
    q.delete();
    @(posedge clk); #1;
    reset = 1'b0;
    mdl[2][8] = save;
    @(negedge clk);
    chk("t6_hready", {63'd0, hready}, 64'd1);
    chk("t6_hresp", {63'd0, hresp}, 64'd0);
    @(posedge clk); #1;
    xfer(0, 32'h8000_0040, 3'd3, 64'd0, 8'h00, w0);
    idle();
    chk("sb_drained", 64'(q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
